// File: rtl/uart_tx_pkg.sv
// Shared definitions for the MMIO UART transmitter: register offsets and FSM states.
package uart_tx_pkg;

   localparam logic [31:0] TXDATA_OFS = 32'd0;
   localparam logic [31:0] STATUS_OFS = 32'd1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; a push while full is accepted only alongside a pop.
module uart_tx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [7:0]               din_i,
   output logic [7:0]               dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o  = mem_q[rd_q];
   assign count_o = count_q;

   always_comb begin
      wr_d    = do_push ? wr_q + AW'(1) : wr_q;
      rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, byte FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frames).
module mmio_uart_tx
   import uart_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'd60,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] ram_rnum,
   input  logic [31:0] ram_wnum,
   input  logic [31:0] ram_wdata,
   input  logic        ram_write,
   output logic [31:0] ram_rdata,
   output logic        txd
);

   localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [31:0] TX_ADDR  = BASE_ADDR + TXDATA_OFS;
   localparam logic [31:0] ST_ADDR  = BASE_ADDR + STATUS_OFS;

   state_e        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          txd_q, txd_d;
   logic          ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   logic          push, pop, full, empty, stat_wr, tick, busy;
   logic [7:0]    fifo_dout, count8;
   logic [CW-1:0] count;
   wire           unused_wdata = ^ram_wdata[31:8];

   // Writes are qualified with reset so nothing lands in the cycle reset is held.
   assign push    = reset && ram_write && (ram_wnum == TX_ADDR);
   assign stat_wr = reset && ram_write && (ram_wnum == ST_ADDR);
   assign tick    = (cnt_q == BIT_LAST);
   assign count8  = 8'(count);
   assign txd     = txd_q;

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (ram_wdata[7:0]),
      .dout_o  (fifo_dout),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (state_q != ST_IDLE) cnt_d = tick ? '0 : cnt_q + 16'd1;
      unique case (state_q)
         ST_IDLE:  if (!empty) begin
            pop     = 1'b1;
            state_d = ST_START;
         end
         ST_START: if (tick) state_d = ST_DATA;
         ST_DATA:  if (tick) begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
            if (bit_q == 3'd7) state_d = ST_PARITY;
`else
            if (bit_q == 3'd7) state_d = ST_STOP;
`endif
         end
         ST_PARITY: if (tick) state_d = ST_STOP;
         ST_STOP:  if (tick) begin
            // Back-to-back frames: the next start bit follows the stop bit directly.
            pop     = !empty;
            state_d = empty ? ST_IDLE : ST_START;
         end
         default:  state_d = ST_IDLE;
      endcase
      if (pop) begin
         shift_d = fifo_dout;
         bit_d   = '0;
         cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
         par_d   = ^fifo_dout;
`endif
      end
   end

   always_comb begin
      busy  = (state_q != ST_IDLE);
      txd_d = 1'b1;
      unique case (state_q)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: txd_d = par_q;
`endif
         default:   txd_d = 1'b1;
      endcase
   end

   always_comb begin
      ovf_d = ovf_q;
      if (stat_wr)                    ovf_d = 1'b0;
      else if (push && full && !pop)  ovf_d = 1'b1;
   end

   always_comb begin
      ram_rdata = '0;
      if (ram_rnum == ST_ADDR)
         ram_rdata = {16'b0, count8, 4'b0, ovf_q, empty, full, busy};
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=8, BASE_ADDR=60.
module tb_mmio_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int CPB = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] ram_rnum = 32'd61;
   logic [31:0] ram_wnum = '0;
   logic [31:0] ram_wdata = '0;
   logic        ram_write = 1'b0;
   logic [31:0] ram_rdata;
   logic        txd;

   int total = 0;
   int bad   = 0;

   mmio_uart_tx #(.BASE_ADDR(32'd60), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .ram_rnum  (ram_rnum),
      .ram_wnum  (ram_wnum),
      .ram_wdata (ram_wdata),
      .ram_write (ram_write),
      .ram_rdata (ram_rdata),
      .txd       (txd)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      ram_write = 1'b1;
      ram_wnum  = addr;
      ram_wdata = data;
      tick();
      ram_write = 1'b0;
   endtask

   // Serial frame: start 0, data LSB first, optional even parity, stop 1.
   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (FB == 11 && idx == 9) return ^b;
      return 1'b1;
   endfunction

   initial begin
      logic [7:0] q3 [3];
      q3[0] = 8'h01; q3[1] = 8'h80; q3[2] = 8'hFF;

      tick();
      tick();
      chk("reset_txd", {31'b0, txd}, 32'd1);
      chk("reset_status", ram_rdata, 32'h0000_0004);
      reset = 1'b1;
      tick();

      // Single 0x55 frame from idle
      wr(32'd60, 32'h0000_0055);
      for (int i = 1; i <= CPB*FB + 1; i++) begin
         tick();
         if (i == 1) begin
            chk("pre_start_txd", {31'b0, txd}, 32'd1);
            chk("busy_after_pop", {31'b0, ram_rdata[0]}, 32'd1);
         end else begin
            chk("frame55_txd", {31'b0, txd}, {31'b0, frame_bit(8'h55, (i-2)/CPB)});
         end
         if (i == CPB*FB)     chk("busy_last", {31'b0, ram_rdata[0]}, 32'd1);
         if (i == CPB*FB + 1) chk("busy_done", {31'b0, ram_rdata[0]}, 32'd0);
      end

      // Overflow: 10 writes while a frame is in flight
      wr(32'd60, 32'h0000_003C);
      tick();
      for (int i = 0; i < 10; i++) wr(32'd60, 32'(i));
      chk("ovf_status", ram_rdata, 32'h0000_080B);
      wr(32'd61, 32'h0);
      chk("ovf_cleared", ram_rdata, 32'h0000_0803);

      // Reset pulse mid DATA, with a concurrent write that must be ignored
      tick();
      reset     = 1'b0;
      ram_write = 1'b1;
      ram_wnum  = 32'd60;
      ram_wdata = 32'h0000_00AA;
      tick();
      reset     = 1'b1;
      ram_write = 1'b0;
      chk("rst_txd", {31'b0, txd}, 32'd1);
      chk("rst_status", ram_rdata, 32'h0000_0004);
      tick();
      chk("rst_write_ignored", ram_rdata, 32'h0000_0004);
      chk("rst_txd_idle", {31'b0, txd}, 32'd1);

      // Three queued bytes sent back to back
      for (int k = 0; k < 3; k++) wr(32'd60, {24'b0, q3[k]});
      for (int j = 0; j < 3*FB*CPB; j++) begin
         if (j != 0) tick();
         chk("burst_txd", {31'b0, txd},
             {31'b0, frame_bit(q3[j/(FB*CPB)], (j/CPB) % FB)});
      end
      tick();
      tick();
      chk("burst_idle", ram_rdata, 32'h0000_0004);

      // Decode: unmapped and TXDATA read as zero; BASE+2 write is ignored
      ram_rnum = 32'd70;
      #1;
      chk("rd_unmapped", ram_rdata, 32'h0);
      ram_rnum = 32'd60;
      #1;
      chk("rd_txdata", ram_rdata, 32'h0);
      ram_rnum = 32'd61;
      wr(32'd62, 32'h0000_00AA);
      tick();
      chk("wr_unmapped", ram_rdata, 32'h0000_0004);
      chk("wr_unmapped_txd", {31'b0, txd}, 32'd1);

`ifdef UART_TX_PARITY_EN
      // 0x07 has odd weight, so the even-parity bit is 1
      wr(32'd60, 32'h0000_0007);
      for (int i = 1; i <= 45; i++) begin
         tick();
         if (i >= 2) chk("par_txd", {31'b0, txd}, {31'b0, frame_bit(8'h07, (i-2)/CPB)});
         if (i == 38) chk("par_bit", {31'b0, txd}, 32'd1);
         if (i == 44) chk("par_busy44", {31'b0, ram_rdata[0]}, 32'd1);
         if (i == 45) chk("par_busy45", {31'b0, ram_rdata[0]}, 32'd0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'd60, word index of the TXDATA register on the data-memory bus.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit, legal range 2..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries, power of two, legal range 2..256.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port ram_rnum, input, 32, read word index from the CPU.
REQ-007 SHALL have port ram_wnum, input, 32, write word index from the CPU.
REQ-008 SHALL have port ram_wdata, input, 32, write data from the CPU.
REQ-009 SHALL have port ram_write, input, 1, write strobe from the CPU.
REQ-010 SHALL have port ram_rdata, output, 32, read data to the CPU.
REQ-011 SHALL have port txd, output, 1, serial line, idle high.

Function
REQ-012 SHALL decode TXDATA at BASE_ADDR and STATUS at BASE_ADDR+1; all other indices unmapped.
REQ-013 SHALL drive ram_rdata combinationally from ram_rnum: STATUS gives {16'b0, count[7:0], 4'b0, overflow, empty, full, busy}; TXDATA and unmapped indices give 0.
REQ-014 SHALL push ram_wdata[7:0] into the FIFO on a rising edge with ram_write=1 and ram_wnum==BASE_ADDR.
REQ-015 SHALL, on a push while full with no same-cycle pop, drop the byte and set sticky overflow.
REQ-016 SHALL accept a push while full when a pop occurs in the same cycle; count stays unchanged.
REQ-017 SHALL clear overflow on any write to STATUS; a write to STATUS has no other effect.
REQ-018 SHALL run the FSM IDLE -> START -> DATA -> STOP -> IDLE, with PARITY between DATA and STOP only when REQ-026 applies.
REQ-019 SHALL, in IDLE with FIFO non-empty, pop one byte into the shift register and enter START on the next edge.
REQ-020 SHALL hold each bit for exactly CLKS_PER_BIT cycles: START drives 0, DATA drives 8 bits LSB first, STOP drives 1.
REQ-021 SHALL go from STOP directly to START when the FIFO is non-empty, with no idle bit; otherwise it goes to IDLE.
REQ-022 SHALL assert busy whenever the state is not IDLE.
REQ-023 SHALL begin the start bit on txd 2 cycles after the write edge when idle: one edge to push, one edge to pop.

Reset
REQ-024 SHALL, while reset=0 at a rising edge, force state IDLE, txd=1, FIFO empty (count=0), overflow=0 and all counters 0; a character in flight is abandoned.
REQ-025 SHALL ignore bus writes during any cycle in which reset=0.

Configuration
REQ-026 SHALL, when UART_TX_PARITY_EN is defined, insert a PARITY state of CLKS_PER_BIT cycles that drives the XOR of the 8 data bits (even parity); a frame is 11 bits.
REQ-027 SHALL, when UART_TX_PARITY_EN is undefined, omit the PARITY state entirely; a frame is 10 bits.

Structure
REQ-028 SHALL place the FSM state enum and the register offsets (TXDATA_OFS=0, STATUS_OFS=1) in shared package uart_tx_pkg.
REQ-029 SHALL implement the FIFO as sub-module uart_tx_fifo with push, pop, data in, data out, full, empty and count.

Verification
REQ-030 SHALL cover: CLKS_PER_BIT=4, write 0x55 to TXDATA while idle -> txd = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles, start bit at write edge + 2, busy=0 after 40 cycles.
REQ-031 SHALL cover: FIFO_DEPTH=8, 10 back-to-back writes while a frame is in progress -> 8 accepted, overflow=1, STATUS read shows full=1; then write STATUS -> overflow=0.
REQ-032 SHALL cover: 3 queued bytes 0x01, 0x80, 0xFF -> three contiguous frames with no idle high between the stop bit and the next start bit.
REQ-033 SHALL cover: reset=0 for 1 cycle in the middle of the DATA state -> next cycle txd=1, STATUS reads 0x00000004 (empty only).
REQ-034 SHALL cover: with UART_TX_PARITY_EN defined, write 0x07 -> parity bit 1, frame of 11 bits, busy for 44 cycles at CLKS_PER_BIT=4.
REQ-035 SHALL cover: ram_rnum set to an unmapped index and to BASE_ADDR -> ram_rdata=0 in both cases; a write to BASE_ADDR+2 does not change the FIFO.
